// File: rtl/dmux_8way16bit_reg_chip.sv
// Registered 8-way demultiplexer/dispatcher. One word per cycle enters on a
// valid/ready port and is routed to one channel (sel) or to all eight (bcast).
// Each channel is a one-entry holding register with its own valid/ready pair.
module dmux_8way16bit_reg_chip #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         sel,
  input  logic               bcast,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic               busy
);

  logic [7:0]       full_q, full_d;
  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       free;
  logic [7:0]       target;
  logic [7:0]       load;
  logic             accept;

  // Slot availability, accept decision and per-slot load mask
  always_comb begin
    free     = ~full_q | out_ready;
    in_ready = bcast ? (&free) : free[sel];
    accept   = in_valid && in_ready;
    target   = bcast ? 8'hFF : (8'h01 << sel);
    load     = accept ? target : 8'h00;
    // Load wins over drain, so a slot loaded while draining stays full.
    full_d   = load | (full_q & ~out_ready);
  end

  // Full flags and holding registers; data retained after drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < 8; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  // Output packing
  always_comb begin
    out_valid = full_q;
    busy      = |full_q;
    for (int i = 0; i < 8; i++) begin
      out_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

endmodule
